z80_seq_ld_ind_nn_a: RTL and testbench

//  Multi-cycle executor for LD (nn),A (opcode 0x32): the store counterpart of LD A,(nn).

---
 rtl/z80_seq_ld_ind_nn_a.sv | 234 +++++++++++++++++++++++
 tb/tb_z80_seq_ld_ind_nn_a.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_seq_ld_ind_nn_a.sv
`default_nettype none
// ============================================================================
// Module      : z80_seq_ld_ind_nn_a
// Description : Multi-cycle executor for Z80 LD (nn),A (opcode 0x32).
//               Fetches the little-endian operand nn from IP+1/IP+2, stores
//               A to (nn) and emits a one-cycle z80fi retire record.
// Revision    : 1.0 - initial release
// ============================================================================
module z80_seq_ld_ind_nn_a #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ip_in,
  input  logic [7:0]  reg_a,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] ip_out,
  output logic        fi_valid,
  output logic [23:0] fi_insn,
  output logic [15:0] fi_mem_waddr,
  output logic [7:0]  fi_mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Last wait-count value tolerated before the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [7:0] OPCODE    = 8'h32;

  state_t      state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  wait_q, wait_d;
  logic        wait_expired;

  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] ip_out_q, ip_out_d;
  logic        fi_valid_q, fi_valid_d;
  logic [23:0] fi_insn_q, fi_insn_d;
  logic [15:0] fi_waddr_q, fi_waddr_d;
  logic [7:0]  fi_wdata_q, fi_wdata_d;

  assign wait_expired = (wait_q == WAIT_LAST);

  // Sequencing: advance on ready, count stalls, abandon on timeout.
  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    a_d     = a_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ip_d    = ip_in;
          a_d     = reg_a;
          state_d = S_RD_LO;
          wait_d  = '0;
        end
      end
      S_RD_LO: begin
        if (mem_ready) begin
          lo_d    = mem_rdata;
          state_d = S_RD_HI;
          wait_d  = '0;
        end else if (wait_expired) begin
          state_d = S_ERR;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RD_HI: begin
        if (mem_ready) begin
          hi_d    = mem_rdata;
          state_d = S_WR;
          wait_d  = '0;
        end else if (wait_expired) begin
          state_d = S_ERR;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WR: begin
        if (mem_ready) begin
          state_d = S_DONE;
          wait_d  = '0;
        end else if (wait_expired) begin
          state_d = S_ERR;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Output values for the state being entered, so strobes are registered.
  always_comb begin
    mem_addr_d  = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = 1'b0;
    err_d       = 1'b0;
    ip_out_d    = '0;
    fi_valid_d  = 1'b0;
    fi_insn_d   = '0;
    fi_waddr_d  = '0;
    fi_wdata_d  = '0;
    unique case (state_d)
      S_RD_LO: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = ip_d + 16'd1;
      end
      S_RD_HI: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = ip_d + 16'd2;
      end
      S_WR: begin
        mem_wr_d    = 1'b1;
        mem_addr_d  = {hi_d, lo_d};
        mem_wdata_d = a_d;
      end
      S_DONE: begin
        done_d     = 1'b1;
        ip_out_d   = ip_d + 16'd3;
        fi_valid_d = 1'b1;
        fi_insn_d  = {hi_d, lo_d, OPCODE};
        fi_waddr_d = {hi_d, lo_d};
        fi_wdata_d = a_d;
      end
      S_ERR: begin
        done_d   = 1'b1;
        err_d    = 1'b1;
        ip_out_d = ip_d;
      end
      default: ;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ip_q        <= '0;
      a_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ip_out_q    <= '0;
      fi_valid_q  <= 1'b0;
      fi_insn_q   <= '0;
      fi_waddr_q  <= '0;
      fi_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      a_q         <= a_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ip_out_q    <= ip_out_d;
      fi_valid_q  <= fi_valid_d;
      fi_insn_q   <= fi_insn_d;
      fi_waddr_q  <= fi_waddr_d;
      fi_wdata_q  <= fi_wdata_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign ip_out       = ip_out_q;
  assign fi_valid     = fi_valid_q;
  assign fi_insn      = fi_insn_q;
  assign fi_mem_waddr = fi_waddr_q;
  assign fi_mem_wdata = fi_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_seq_ld_ind_nn_a.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_seq_ld_ind_nn_a
// Description : Self-checking bench for the LD (nn),A executor with a
//               64 KiB memory model and stall-programmable bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_seq_ld_ind_nn_a;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ip_in = '0;
  logic [7:0]  reg_a = '0;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy, done, err, fi_valid;
  logic [15:0] ip_out, fi_mem_waddr;
  logic [23:0] fi_insn;
  logic [7:0]  fi_mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];
  int wait_rd = 0;
  int wait_wr = 0;
  int stall = 0;
  int nwrites = 0;

  always #5 clk = ~clk;

  z80_seq_ld_ind_nn_a #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .ip_in(ip_in), .reg_a(reg_a),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .ip_out(ip_out), .fi_valid(fi_valid), .fi_insn(fi_insn),
    .fi_mem_waddr(fi_mem_waddr), .fi_mem_wdata(fi_mem_wdata)
  );

  // Bus responder: ready rises after a programmable number of stall cycles.
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_wr ? (stall >= wait_wr) : (stall >= wait_rd);

  // Stall counter and memory write commit.
  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) stall <= stall + 1;
    else stall <= 0;
    if (mem_wr && mem_ready && !reset) begin
      mem[mem_addr] = mem_wdata;
      nwrites = nwrites + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done (bounded), checking bus protocol every cycle.
  task automatic wait_done(output int n);
    logic [15:0] pa;
    logic        ps;
    n  = 0;
    ps = 1'b0;
    pa = '0;
    while (!done && n < 2000) begin
      chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (ps && (mem_rd || mem_wr)) chk("addr_held", 32'(mem_addr), 32'(pa));
      ps = (mem_rd || mem_wr) && !mem_ready;
      pa = mem_addr;
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // One instruction checked against the architectural model.
  task automatic run_insn(input logic [15:0] ip, input logic [7:0] a, input int wrd, input int wwr);
    logic [15:0] p1, p2, nn;
    logic [7:0]  old;
    int          w0, n, exp_lat;
    bit          ab;
    p1 = ip + 16'd1;
    p2 = ip + 16'd2;
    nn = {mem[p2], mem[p1]};
    old = mem[nn];
    w0 = nwrites;
    wait_rd = wrd;
    wait_wr = wwr;
    ab = (wrd >= MAXW) || (wwr >= MAXW);
    if (wrd >= MAXW) exp_lat = 1 + MAXW;
    else if (wwr >= MAXW) exp_lat = 1 + 2 * (wrd + 1) + MAXW;
    else exp_lat = 1 + 2 * (wrd + 1) + (wwr + 1);
    start = 1'b1; ip_in = ip; reg_a = a;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("latency", 32'(n + 1), 32'(exp_lat));
    chk("err", 32'(err), 32'(ab));
    chk("fi_valid", 32'(fi_valid), 32'(!ab));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("strobes_at_done", 32'({mem_rd, mem_wr}), 32'd0);
    chk("ip_out", 32'(ip_out), ab ? 32'(ip) : 32'(p2 + 16'd1));
    if (!ab) begin
      chk("fi_insn", 32'(fi_insn), 32'({nn, 8'h32}));
      chk("fi_mem_waddr", 32'(fi_mem_waddr), 32'(nn));
      chk("fi_mem_wdata", 32'(fi_mem_wdata), 32'(a));
      chk("mem_written", 32'(mem[nn]), 32'(a));
      chk("write_count", 32'(nwrites - w0), 32'd1);
    end else begin
      chk("mem_unchanged", 32'(mem[nn]), 32'(old));
      chk("no_write", 32'(nwrites - w0), 32'd0);
    end
    @(posedge clk); #1;
    chk("after_done", 32'({done, busy, err, fi_valid}), 32'd0);
  endtask

  initial begin
    int n, w0, wrd, wwr;
    logic [15:0] rip;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", 32'({mem_addr, mem_rd, mem_wr, mem_wdata}), 32'd0);
    chk("rst_ctl", 32'({busy, done, err, fi_valid}), 32'd0);
    chk("rst_ip_out", 32'(ip_out), 32'd0);
    chk("rst_fi", 32'({fi_insn, fi_mem_wdata}), 32'd0);
    chk("rst_fi_waddr", 32'(fi_mem_waddr), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: basic store, zero-wait bus
    mem[16'h1001] = 8'h34; mem[16'h1002] = 8'h12;
    run_insn(16'h1000, 8'h5A, 0, 0);
    chk("t1_mem1234", 32'(mem[16'h1234]), 32'h5A);

    // 2: operand fetch wraps around 0xFFFF, target 0xFFFF
    mem[16'hFFFF] = 8'hFF; mem[16'h0000] = 8'hFF;
    run_insn(16'hFFFE, 8'hA7, 0, 0);
    chk("t2_memFFFF", 32'(mem[16'hFFFF]), 32'hA7);

    // 3: three wait cycles in every phase
    mem[16'h1001] = 8'h34; mem[16'h1002] = 8'h12;
    run_insn(16'h1000, 8'h5A, 3, 3);

    // 4: write never acknowledged -> timeout abort
    run_insn(16'h1000, 8'h99, 0, 100);

    // 5a: reset during RD_HI
    wait_rd = 0; wait_wr = 0; w0 = nwrites;
    start = 1'b1; ip_in = 16'h2000; reg_a = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t5_in_rd_hi", 32'({mem_rd, mem_addr}), 32'h12002);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_reset_idle", 32'({busy, done, mem_rd, mem_wr}), 32'd0);
    @(posedge clk); #1;
    chk("t5_no_done", 32'({busy, done}), 32'd0);
    chk("t5_no_write", 32'(nwrites - w0), 32'd0);

    // 5b: reset coinciding with ready in WR
    start = 1'b1; ip_in = 16'h2100; reg_a = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_in_wr", 32'({mem_wr, mem_ready}), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_wr_reset", 32'({busy, done, mem_wr}), 32'd0);
    @(posedge clk); #1;
    chk("t5_wr_no_done", 32'(done), 32'd0);
    run_insn(16'h2000, 8'h3C, 1, 2);

    // 6: start held high while busy and in the DONE cycle
    wait_rd = 0; wait_wr = 0; w0 = nwrites;
    start = 1'b1; ip_in = 16'h3000; reg_a = 8'hC3;
    @(posedge clk); #1;
    wait_done(n);
    chk("t6_latency", 32'(n + 1), 32'd4);
    chk("t6_ip_out", 32'(ip_out), 32'h3003);
    @(posedge clk); #1;
    chk("t6_idle", 32'({busy, done}), 32'd0);
    @(posedge clk); #1;
    chk("t6_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("t6_second_latency", 32'(n + 1), 32'd4);
    chk("t6_writes", 32'(nwrites - w0), 32'd2);
    @(posedge clk); #1;

    // Randomized instructions, including occasional timeouts
    for (int i = 0; i < 24; i++) begin
      rip = (i % 5 == 4) ? 16'(16'hFFFD + 16'($urandom_range(0, 2))) : 16'($urandom);
      wrd = $urandom_range(0, 3);
      wwr = $urandom_range(0, 3);
      if (i % 6 == 5) wwr = MAXW;
      if (i % 8 == 7) wrd = MAXW;
      run_insn(rip, 8'($urandom), wrd, wwr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
